// File: rtl/tetris_pkg.sv
// tetris_pkg: button indices, encoded button codes and pad reader state encoding
package tetris_pkg;
   localparam int BTN_IDX_A      = 0;
   localparam int BTN_IDX_B      = 1;
   localparam int BTN_IDX_SELECT = 2;
   localparam int BTN_IDX_START  = 3;
   localparam int BTN_IDX_UP     = 4;
   localparam int BTN_IDX_DOWN   = 5;
   localparam int BTN_IDX_LEFT   = 6;
   localparam int BTN_IDX_RIGHT  = 7;
   localparam logic [3:0] BTN_NONE   = 4'b0000;
   localparam logic [3:0] BTN_A      = 4'b0001;
   localparam logic [3:0] BTN_B      = 4'b0010;
   localparam logic [3:0] BTN_SELECT = 4'b0011;
   localparam logic [3:0] BTN_START  = 4'b0100;
   localparam logic [3:0] BTN_UP     = 4'b0101;
   localparam logic [3:0] BTN_DOWN   = 4'b0110;
   localparam logic [3:0] BTN_LEFT   = 4'b0111;
   localparam logic [3:0] BTN_RIGHT  = 4'b1000;
   typedef logic [2:0] pad_state_t;
   localparam pad_state_t ST_IDLE   = 3'd0;
   localparam pad_state_t ST_LATCH  = 3'd1;
   localparam pad_state_t ST_GAP    = 3'd2;
   localparam pad_state_t ST_CLK_HI = 3'd3;
   localparam pad_state_t ST_CLK_LO = 3'd4;
   localparam pad_state_t ST_UPDATE = 3'd5;
   // lowest pressed index wins; code is index+1
   function automatic logic [3:0] btn_encode(input logic [7:0] b);
      logic [3:0] c;
      c = BTN_NONE;
      for (int i = 7; i >= 0; i--)
         if (b[i]) c = 4'(i + 1);
      return c;
   endfunction
endpackage

// File: rtl/nes_pad_if.sv
// nes_pad_if: serial pad wires plus the decoded button outputs
interface nes_pad_if;
   logic       pad_data;
   logic       pad_latch;
   logic       pad_clk;
   logic [7:0] buttons;
   logic [3:0] controller_out;
   logic       frame_valid;
   modport master (input pad_data, output pad_latch, pad_clk, buttons, controller_out, frame_valid);
   modport slave (output pad_data, input pad_latch, pad_clk, buttons, controller_out, frame_valid);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: accepts a frame only after DEBOUNCE_POLLS identical polls
module button_debouncer
   import tetris_pkg::*;
#(
   parameter int DEBOUNCE_POLLS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] raw,
   input  logic       update,
   output logic [7:0] buttons,
   output logic [3:0] controller_out,
   output logic       frame_valid
);
   localparam logic [2:0] DB = 3'(DEBOUNCE_POLLS);
   logic [7:0] prev_raw;
   logic [2:0] stable_cnt, cnt_next;
   always_comb cnt_next = raw != prev_raw ? 3'd1 : stable_cnt == DB ? DB : stable_cnt + 3'd1;
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev_raw       <= '0;
         stable_cnt     <= '0;
         buttons        <= '0;
         controller_out <= BTN_NONE;
         frame_valid    <= 1'b0;
      end else begin
         frame_valid <= update;
         if (update) begin
            stable_cnt <= cnt_next;
            prev_raw   <= raw;
            if (cnt_next == DB) begin
               buttons        <= raw;
               controller_out <= btn_encode(raw);
            end
         end
      end
   end
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES serial pad, generates latch/clock strobes and
// presents debounced buttons plus a priority code
module nes_pad_reader
   import tetris_pkg::*;
#(
   parameter int HALF_BIT_CYCLES = 300,
   parameter int POLL_CYCLES     = 833333,
   parameter int DEBOUNCE_POLLS  = 2
) (
   input logic      clk,
   input logic      reset,
   nes_pad_if.master pad
);
   localparam int PW  = $clog2(POLL_CYCLES);
   localparam int PHW = $clog2(2 * HALF_BIT_CYCLES);
   localparam logic [PW-1:0]  POLL_END = PW'(POLL_CYCLES - 1);
   localparam logic [PHW-1:0] PH_H     = PHW'(HALF_BIT_CYCLES - 1);
   localparam logic [PHW-1:0] PH_2H    = PHW'(2 * HALF_BIT_CYCLES - 1);
   logic [PW-1:0]  poll_cnt;
   logic [PHW-1:0] phase;
   logic [2:0]     k;
   logic [7:0]     raw;
   logic           s1, s2, last, sample;
   pad_state_t     state, state_next;
   always_comb begin
      last       = state == ST_LATCH ? phase == PH_2H : phase == PH_H;
      sample     = last && (state == ST_GAP || state == ST_CLK_LO);
      state_next = state == ST_IDLE   ? (poll_cnt == POLL_END ? ST_LATCH : ST_IDLE) :
                   state == ST_UPDATE ? ST_IDLE :
                   !last              ? state :
                   state == ST_LATCH  ? ST_GAP :
                   state == ST_CLK_HI ? ST_CLK_LO :
                   state == ST_CLK_LO ? (k == 3'd7 ? ST_UPDATE : ST_CLK_HI) : ST_CLK_HI;
   end
   // k wraps 7->0 after the last sample so the next GAP samples bit 0
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1            <= 1'b1;
         s2            <= 1'b1;
         poll_cnt      <= '0;
         phase         <= '0;
         k             <= '0;
         raw           <= '0;
         state         <= ST_IDLE;
         pad.pad_latch <= 1'b0;
         pad.pad_clk   <= 1'b0;
      end else begin
         s1            <= pad.pad_data;
         s2            <= s1;
         poll_cnt      <= poll_cnt == POLL_END ? '0 : poll_cnt + 1'b1;
         state         <= state_next;
         phase         <= (state_next != state || state == ST_IDLE) ? '0 : phase + 1'b1;
         pad.pad_latch <= state_next == ST_LATCH;
         pad.pad_clk   <= state_next == ST_CLK_HI;
         if (sample) begin
            raw[k] <= ~s2;
            k      <= k + 3'd1;
         end
      end
   end
   button_debouncer #(.DEBOUNCE_POLLS(DEBOUNCE_POLLS)) u_debouncer (
      .clk(clk),
      .reset(reset),
      .raw(raw),
      .update(state == ST_UPDATE),
      .buttons(pad.buttons),
      .controller_out(pad.controller_out),
      .frame_valid(pad.frame_valid)
   );
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: directed frames against a shift-register pad model
module tb_nes_pad_reader;
   logic       clk = 1'b0, reset = 1'b0, pclk_q = 1'b0;
   logic [7:0] btn = 8'h80, sr = 8'hFF;
   int         errors = 0, checks = 0;
   nes_pad_if pad();
   nes_pad_reader #(.HALF_BIT_CYCLES(2), .POLL_CYCLES(64), .DEBOUNCE_POLLS(2)) dut (
      .clk(clk),
      .reset(reset),
      .pad(pad)
   );
   always #5 clk = ~clk;
   assign pad.pad_data = sr[0];
   // pad loads while latch is high and shifts on each pad_clk rise; 0 = pressed
   always @(posedge clk) begin
      pclk_q <= pad.pad_clk;
      if (pad.pad_latch) sr <= ~btn;
      else if (pad.pad_clk && !pclk_q) sr <= {1'b1, sr[7:1]};
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic reset_vals(input string tag);
      check({tag, "_latch"}, 32'(pad.pad_latch), 0);
      check({tag, "_clk"}, 32'(pad.pad_clk), 0);
      check({tag, "_fv"}, 32'(pad.frame_valid), 0);
      check({tag, "_buttons"}, 32'(pad.buttons), 0);
      check({tag, "_code"}, 32'(pad.controller_out), 0);
   endtask
   task automatic wait_latch(input string tag, input int exp_n);
      int n = 0;
      while (!pad.pad_latch && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, n, exp_n);
   endtask
   // entered on the negedge of the first latch cycle, leaves on the next one
   task automatic frame(input logic [7:0] eb, input logic [3:0] ec);
      int nl = 0, nh = 0, nr = 0, nfv = 0, fvt = -1;
      logic pc = 1'b0;
      logic [7:0] b = '0;
      logic [3:0] c = '0;
      for (int t = 0; t < 64; t++) begin
         if (pad.pad_latch) nl++;
         if (pad.pad_clk) nh++;
         if (pad.pad_clk && !pc) nr++;
         pc = pad.pad_clk;
         if (pad.frame_valid) begin
            nfv++;
            fvt = t;
            b = pad.buttons;
            c = pad.controller_out;
         end
         @(negedge clk);
      end
      check("latch_len", nl, 4);
      check("clk_pulses", nr, 7);
      check("clk_high", nh, 14);
      check("fv_count", nfv, 1);
      check("fv_time", fvt, 35);
      check("period", 32'(pad.pad_latch), 1);
      check("buttons", 32'(b), 32'(eb));
      check("code", 32'(c), 32'(ec));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk);
      reset_vals("reset");
      reset = 1'b1;
      wait_latch("first_latch", 64);
      frame(8'h00, 4'b0000);
      frame(8'h80, 4'b1000);
      frame(8'h80, 4'b1000);
      btn = 8'h00;
      frame(8'h80, 4'b1000);
      frame(8'h00, 4'b0000);
      btn = 8'hC0;
      frame(8'h00, 4'b0000);
      frame(8'hC0, 4'b0111);
      btn = 8'h88;
      frame(8'hC0, 4'b0111);
      frame(8'h88, 4'b0100);
      btn = 8'h01;
      repeat (6) @(negedge clk);
      check("mid_clk_hi", 32'(pad.pad_clk), 1);
      reset = 1'b0;
      @(negedge clk);
      reset_vals("mid_reset");
      reset = 1'b1;
      wait_latch("latch_after_reset", 64);
      frame(8'h00, 4'b0000);
      frame(8'h01, 4'b0001);
      btn = 8'h00;
      frame(8'h01, 4'b0001);
      frame(8'h00, 4'b0000);
      btn = 8'h08;
      frame(8'h00, 4'b0000);
      btn = 8'h00;
      frame(8'h00, 4'b0000);
      frame(8'h00, 4'b0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
